// File: rtl/uart2vga_pkg.sv
// Shared definitions for the UART-to-VGA frame path: geometry defaults and
// the row-writer state encoding.
// Latency: n/a. Backpressure: n/a.
package uart2vga_pkg;

  localparam int DEF_WIGHT  = 640;  // pixels per row
  localparam int DEF_HEIGHT = 480;  // rows per frame
  localparam int DEF_PIX_W  = 3;    // bits per pixel (palette index)
  localparam int DEF_ADDR_W = 19;   // frame-RAM address width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } row_state_t;

endpackage

// File: rtl/uart_row_writer.sv
// Writes one received pixel row into the frame RAM, one pixel per cycle.
// Latency: first write the cycle after acceptance; Wight writes, one DONE
//   cycle, ready again Wight+2 cycles after acceptance.
// Backpressure: row_ready is high only in IDLE; a row offered while busy is
//   dropped and flagged in err_overrun; out-of-range rows set err_range.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   row_valid/idx/data     one-cycle row strobe, target row, packed pixels
//   row_ready              row can be accepted
//   ram_addr/data/we       frame-RAM write port (addr/data zero when idle)
//   row_done, frame_done   end-of-row pulse, end-of-frame pulse (same cycle)
//   err_range, err_overrun sticky error flags, cleared only by reset
module uart_row_writer
  import uart2vga_pkg::*;
#(
  parameter int Wight  = DEF_WIGHT,
  parameter int Height = DEF_HEIGHT,
  parameter int PIX_W  = DEF_PIX_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     row_valid,
  input  logic [8:0]               row_idx,
  input  logic [PIX_W*Wight-1:0]   row_data,
  output logic                     row_ready,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [PIX_W-1:0]         ram_data,
  output logic                     ram_we,
  output logic                     row_done,
  output logic                     frame_done,
  output logic                     err_range,
  output logic                     err_overrun
);

  localparam int ROW_BITS = PIX_W * Wight;
  localparam int CNT_W    = $clog2(Wight);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Wight - 1);

  row_state_t            state, state_nxt;
  logic [ROW_BITS-1:0]   shift_q, shift_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_nxt;
  logic [ADDR_W-1:0]     base_q, base_nxt;
  logic                  last_q, last_nxt;

  logic                  ready_nxt, we_nxt, done_nxt, fdone_nxt;
  logic                  range_nxt, over_nxt;
  logic [ADDR_W-1:0]     addr_nxt;
  logic [PIX_W-1:0]      data_nxt;

  logic                  idx_in_range;
  logic                  idx_is_last;
  logic [ADDR_W-1:0]     idx_base;

  assign idx_in_range = (32'(row_idx) < 32'(Height));
  assign idx_is_last  = (32'(row_idx) == 32'(Height - 1));
  assign idx_base     = ADDR_W'(row_idx) * ADDR_W'(Wight);

  // All outputs are registered: the comb block computes their values for the
  // state being entered, so the write port reflects the current WRITE slot.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_q;
    cnt_nxt   = cnt_q;
    base_nxt  = base_q;
    last_nxt  = last_q;
    we_nxt    = 1'b0;
    addr_nxt  = '0;
    data_nxt  = '0;
    done_nxt  = 1'b0;
    fdone_nxt = 1'b0;
    range_nxt = err_range;
    over_nxt  = err_overrun;

    case (state)
      IDLE: begin
        if (row_valid) begin
          if (idx_in_range) begin
            // Pixel 0 goes out immediately; the rest waits in the shifter.
            state_nxt = WRITE;
            shift_nxt = row_data >> PIX_W;
            cnt_nxt   = '0;
            base_nxt  = idx_base;
            last_nxt  = idx_is_last;
            we_nxt    = 1'b1;
            addr_nxt  = idx_base;
            data_nxt  = row_data[PIX_W-1:0];
          end else begin
            range_nxt = 1'b1;
          end
        end
      end
      WRITE: begin
        if (row_valid) over_nxt = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          fdone_nxt = last_q;
        end else begin
          cnt_nxt   = cnt_q + CNT_W'(1);
          we_nxt    = 1'b1;
          addr_nxt  = base_q + ADDR_W'(cnt_nxt);
          data_nxt  = shift_q[PIX_W-1:0];
          shift_nxt = shift_q >> PIX_W;
        end
      end
      DONE: begin
        if (row_valid) over_nxt = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    ready_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      base_q      <= '0;
      last_q      <= 1'b0;
      row_ready   <= 1'b1;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_data    <= '0;
      row_done    <= 1'b0;
      frame_done  <= 1'b0;
      err_range   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_nxt;
      shift_q     <= shift_nxt;
      cnt_q       <= cnt_nxt;
      base_q      <= base_nxt;
      last_q      <= last_nxt;
      row_ready   <= ready_nxt;
      ram_we      <= we_nxt;
      ram_addr    <= addr_nxt;
      ram_data    <= data_nxt;
      row_done    <= done_nxt;
      frame_done  <= fdone_nxt;
      err_range   <= range_nxt;
      err_overrun <= over_nxt;
    end
  end

endmodule

// File: tb/tb_uart_row_writer.sv
// Bench for uart_row_writer: directed scenarios plus random rows, every cycle
// compared against a row-level reference model.
// Latency/backpressure: checked through the model's accept/turnaround rules.
module tb_uart_row_writer;

  localparam int W  = 640;
  localparam int H  = 480;
  localparam int P  = 3;
  localparam int AW = 19;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           row_valid;
  logic [8:0]     row_idx;
  logic [P*W-1:0] row_data;
  logic           row_ready;
  logic [AW-1:0]  ram_addr;
  logic [P-1:0]   ram_data;
  logic           ram_we;
  logic           row_done;
  logic           frame_done;
  logic           err_range;
  logic           err_overrun;

  always #5 clk = ~clk;

  uart_row_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_valid   (row_valid),
    .row_idx     (row_idx),
    .row_data    (row_data),
    .row_ready   (row_ready),
    .ram_addr    (ram_addr),
    .ram_data    (ram_data),
    .ram_we      (ram_we),
    .row_done    (row_done),
    .frame_done  (frame_done),
    .err_range   (err_range),
    .err_overrun (err_overrun)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle window %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // A row accepted at edge n is written in windows n..n+W-1 (window = time
  // after edge), row_done in window n+W, next acceptance possible at n+W+2.
  int             cyc = 0;
  int             next_free = 0;
  bit             m_active = 0;
  int             m_start = 0;
  int             m_base = 0;
  logic [P*W-1:0] m_row = '0;
  int             m_done_cyc = -1;
  bit             m_frame = 0;
  bit             m_err_range = 0;
  bit             m_err_over = 0;
  int             dut_writes = 0;
  int             dut_frames = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      next_free   = 0;
      m_active    = 0;
      m_done_cyc  = -1;
      m_frame     = 0;
      m_err_range = 0;
      m_err_over  = 0;
    end else if (row_valid) begin
      if (cyc >= next_free) begin
        if (int'(row_idx) < H) begin
          m_active   = 1;
          m_start    = cyc;
          m_base     = int'(row_idx) * W;
          m_row      = row_data;
          m_done_cyc = cyc + W;
          m_frame    = (int'(row_idx) == H - 1);
          next_free  = cyc + W + 2;
        end else begin
          m_err_range = 1;
        end
      end else begin
        m_err_over = 1;
      end
    end
  end

  always @(negedge clk) begin
    int  k;
    bit  we_e;
    int  a_e;
    int  d_e;
    bit  done_e;
    k    = cyc - m_start;
    we_e = m_active && (k >= 0) && (k < W);
    a_e  = 0;
    d_e  = 0;
    if (we_e) begin
      a_e = m_base + k;
      d_e = int'(m_row[k*P +: P]);
    end
    done_e = (cyc == m_done_cyc);
    check_val("ram_we",      32'(ram_we),      32'(we_e));
    check_val("ram_addr",    32'(ram_addr),    32'(a_e));
    check_val("ram_data",    32'(ram_data),    32'(d_e));
    check_val("row_done",    32'(row_done),    32'(done_e));
    check_val("frame_done",  32'(frame_done),  32'(done_e && m_frame));
    check_val("row_ready",   32'(row_ready),   32'(cyc >= next_free - 1));
    check_val("err_range",   32'(err_range),   32'(m_err_range));
    check_val("err_overrun", 32'(err_overrun), 32'(m_err_over));
    if (ram_we === 1'b1)     dut_writes++;
    if (frame_done === 1'b1) dut_frames++;
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [P*W-1:0] rand_row();
    logic [P*W-1:0] d;
    for (int i = 0; i < W; i++) d[i*P +: P] = P'($urandom_range(0, 7));
    return d;
  endfunction

  // Caller is at a negedge; strobe for one cycle, then scramble row_data.
  task automatic send_row(input int idx, input logic [P*W-1:0] d);
    row_valid = 1'b1;
    row_idx   = 9'(idx);
    row_data  = d;
    @(negedge clk);
    row_valid = 1'b0;
    row_data  = rand_row();
  endtask

  task automatic wait_ready();
    int t = 0;
    while (row_ready !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (row_ready !== 1'b1) check_val("ready_timeout", 32'(row_ready), 32'd1);
  endtask

  initial begin
    logic [P*W-1:0] d;
    int w0;
    int f0;
    int t;

    rst_n     = 1'b0;
    row_valid = 1'b0;
    row_idx   = '0;
    row_data  = '0;
    repeat (3) @(negedge clk);
    check_val("rst_ready",   32'(row_ready),   32'd1);
    check_val("rst_we",      32'(ram_we),      32'd0);
    check_val("rst_addr",    32'(ram_addr),    32'd0);
    check_val("rst_errs",    32'({err_range, err_overrun}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Row 0, pixel n = n mod 8
    for (int n = 0; n < W; n++) d[n*P +: P] = P'(n % 8);
    w0 = dut_writes;
    send_row(0, d);
    wait_ready();
    check_val("row0_writes", 32'(dut_writes - w0), 32'(W));

    // Last row, all pixels 5: frame_done must fire once
    for (int n = 0; n < W; n++) d[n*P +: P] = 3'b101;
    w0 = dut_writes;
    f0 = dut_frames;
    send_row(H - 1, d);
    wait_ready();
    check_val("row479_writes", 32'(dut_writes - w0), 32'(W));
    check_val("row479_frame",  32'(dut_frames - f0), 32'd1);

    // Out-of-range row
    w0 = dut_writes;
    send_row(H, rand_row());
    repeat (5) @(negedge clk);
    check_val("range_writes", 32'(dut_writes - w0), 32'd0);
    check_val("range_flag",   32'(err_range), 32'd1);
    check_val("range_ready",  32'(row_ready), 32'd1);

    // Overrun: second strobe 10 cycles after the first
    w0 = dut_writes;
    send_row($urandom_range(0, H - 1), rand_row());
    repeat (9) @(negedge clk);
    send_row($urandom_range(0, H - 1), rand_row());
    wait_ready();
    check_val("over_writes", 32'(dut_writes - w0), 32'(W));
    check_val("over_flag",   32'(err_overrun), 32'd1);

    // Reset in the middle of row 5, at write 300
    send_row(5, rand_row());
    t = 0;
    while (!(ram_we === 1'b1 && int'(ram_addr) == 5 * W + 300) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check_val("w300_seen", 32'(ram_addr), 32'(5 * W + 300));
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_we",    32'(ram_we),      32'd0);
    check_val("mid_rst_addr",  32'(ram_addr),    32'd0);
    check_val("mid_rst_ready", 32'(row_ready),   32'd1);
    check_val("mid_rst_flags", 32'({err_range, err_overrun, row_done, frame_done}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w0 = dut_writes;
    send_row($urandom_range(0, H - 1), rand_row());
    wait_ready();
    check_val("post_rst_writes", 32'(dut_writes - w0), 32'(W));

    // Back-to-back rows 1 and 2, second strobe on the first ready cycle
    w0 = dut_writes;
    send_row(1, rand_row());
    wait_ready();
    send_row(2, rand_row());
    wait_ready();
    check_val("b2b_writes",  32'(dut_writes - w0), 32'(2 * W));
    check_val("b2b_overrun", 32'(err_overrun), 32'd0);

    // Random rows with random spacing (some overlap, some out of range)
    for (int r = 0; r < 4; r++) begin
      send_row($urandom_range(0, 511), rand_row());
      repeat ($urandom_range(1, 700)) @(negedge clk);
    end
    wait_ready();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
